key_sequence_player: RTL and testbench

Generates button-press stimulus for the password authenticator, the sending end of its T/D/L/R button interface. A programmable sequence of up to 8 direction codes is stored locally. On `start` the block replays the sequence as one-hot button pulses of fixed hold and gap length. It sits on the board next to the authenticator as an on-chip self-test and auto-entry source, with its outputs ORed with the physical debounced buttons.

---
 rtl/key_seq_pkg.sv | 33 +++
 rtl/key_seq_mem.sv | 25 ++
 rtl/key_sequence_player.sv | 160 ++++++++++++++++
 tb/tb_key_sequence_player.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_seq_pkg.sv
// Shared types for the key sequence player: direction codes, FSM states, button decode.
// Pure declarations; no latency or backpressure of its own.
// Optional KEY_SEQ_ABORT_EN feature lives in key_sequence_player, not here.
package key_seq_pkg;

    typedef enum logic [1:0] {
        DIR_T = 2'b00,
        DIR_D = 2'b01,
        DIR_L = 2'b10,
        DIR_R = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP,
        FIN
    } state_t;

    // Bit order is {T, D, L, R}.
    function automatic logic [3:0] dir_to_onehot(input dir_t dir);
        logic [3:0] onehot;
        onehot = 4'b0000;
        case (dir)
            DIR_T:   onehot = 4'b1000;
            DIR_D:   onehot = 4'b0100;
            DIR_L:   onehot = 4'b0010;
            default: onehot = 4'b0001;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/key_seq_mem.sv
// MAX_LEN x 2 sequence register file, one synchronous write port, one async read port.
// Write lands on the next clk edge; read is combinational. No backpressure, no reset.
module key_seq_mem #(
    parameter int MAX_LEN = 8,
    parameter int AW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [1:0]    rd_dat
);

    logic [1:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/key_sequence_player.sv
// Replays a stored direction sequence as one-hot T/D/L/R pulses of fixed hold and gap length.
// First button rises one cycle after start is sampled; done pulses the cycle after the last gap.
// No backpressure: start outside IDLE/FIN is dropped. KEY_SEQ_ABORT_EN adds abort/aborted.
module key_sequence_player
    import key_seq_pkg::*;
#(
    parameter int MAX_LEN     = 8,
    parameter int HOLD_CYCLES = 3,
    parameter int GAP_CYCLES  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(MAX_LEN)-1:0] wr_addr,
    input  logic [1:0]                 wr_dir,
    input  logic [$clog2(MAX_LEN):0]   seq_len,
    input  logic                       start,
    output logic                       T,
    output logic                       D,
    output logic                       L,
    output logic                       R,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(MAX_LEN)-1:0] step
`ifdef KEY_SEQ_ABORT_EN
    ,
    input  logic                       abort,
    output logic                       aborted
`endif
);

    localparam int AW    = $clog2(MAX_LEN);
    localparam int LW    = AW + 1;
    localparam int TMAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

    state_t          state;
    logic [AW-1:0]   idx;
    logic [LW-1:0]   len_q;
    logic [TW-1:0]   timer;
    logic [3:0]      btn_q;
    logic            busy_q;
    logic            done_q;
`ifdef KEY_SEQ_ABORT_EN
    logic            aborted_q;
`endif

    logic            can_write;
    logic            mem_we;
    logic [AW-1:0]   rd_addr;
    logic [1:0]      rd_dat;
    logic [1:0]      next_dir;
    logic [LW-1:0]   sat_len;
    logic            last_entry;

    assign can_write = (state == IDLE) || (state == FIN);
    assign mem_we    = wr_en && can_write;

    // Reads the entry that will play next: entry 0 when starting, idx+1 when advancing.
    assign rd_addr = can_write ? '0 : idx + AW'(1);

    // A write in the start cycle must be visible to the first button.
    assign next_dir = (mem_we && (wr_addr == rd_addr)) ? wr_dir : rd_dat;

    assign sat_len    = (seq_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : seq_len;
    assign last_entry = ({1'b0, idx} == (len_q - LW'(1)));

    key_seq_mem #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_addr),
        .wr_dat  (wr_dir),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            btn_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            idx    <= '0;
            len_q  <= '0;
            timer  <= '0;
`ifdef KEY_SEQ_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef KEY_SEQ_ABORT_EN
            aborted_q <= 1'b0;
`endif
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        len_q <= sat_len;
                        idx   <= '0;
                        if (sat_len == '0) begin
                            state  <= FIN;
                            done_q <= 1'b1;
                            timer  <= '0;
                        end else begin
                            state  <= HOLD;
                            btn_q  <= dir_to_onehot(dir_t'(next_dir));
                            busy_q <= 1'b1;
                            timer  <= HOLD_LOAD;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                HOLD, GAP: begin
`ifdef KEY_SEQ_ABORT_EN
                    if (abort) begin
                        state     <= IDLE;
                        btn_q     <= '0;
                        busy_q    <= 1'b0;
                        idx       <= '0;
                        timer     <= '0;
                        aborted_q <= 1'b1;
                    end else
`endif
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else if (state == HOLD) begin
                        state <= GAP;
                        btn_q <= '0;
                        timer <= GAP_LOAD;
                    end else if (last_entry) begin
                        state  <= FIN;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        idx    <= '0;
                    end else begin
                        state <= HOLD;
                        idx   <= idx + AW'(1);
                        btn_q <= dir_to_onehot(dir_t'(next_dir));
                        timer <= HOLD_LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign {T, D, L, R} = btn_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign step         = idx;
`ifdef KEY_SEQ_ABORT_EN
    assign aborted      = aborted_q;
`endif

endmodule

// File: tb/tb_key_sequence_player.sv
// Bench for key_sequence_player: vector table, directed multi-cycle sequences, random run vs a cycle-trace model.
// Abort scenarios are compiled in when KEY_SEQ_ABORT_EN is defined.
module tb_key_sequence_player;

    localparam int MAX_LEN = 8;
    localparam int HOLD    = 3;
    localparam int GAP     = 3;
    localparam int AW      = 3;
    localparam int LW      = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, wr_en, start;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_dir;
    logic [LW-1:0] seq_len;
    logic          T, D, L, R, busy, done;
    logic [AW-1:0] step;
`ifdef KEY_SEQ_ABORT_EN
    logic          abort, aborted;
`endif

    key_sequence_player #(
        .MAX_LEN     (MAX_LEN),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dir  (wr_dir),
        .seq_len (seq_len),
        .start   (start),
        .T       (T),
        .D       (D),
        .L       (L),
        .R       (R),
        .busy    (busy),
        .done    (done),
        .step    (step)
`ifdef KEY_SEQ_ABORT_EN
        ,
        .abort   (abort),
        .aborted (aborted)
`endif
    );

    typedef struct packed {
        logic [3:0]    btn;
        logic          busy;
        logic          done;
        logic [AW-1:0] step;
        logic          ab;
    } out_t;

    typedef struct {
        logic          rst;
        logic          we;
        logic [AW-1:0] wa;
        logic [1:0]    wd;
        logic          st;
        logic [LW-1:0] sl;
        logic [3:0]    btn;
        logic          busy;
        logic          done;
        logic [AW-1:0] step;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    out_t act;
    out_t exp_cur = '0;
    out_t q[$];
    logic [1:0] mmem [MAX_LEN];

    // {T,D,L,R}: code 0 is the MSB, code 3 the LSB.
    function automatic logic [3:0] onehot(input logic [1:0] d);
        return 4'b1000 >> d;
    endfunction

    function automatic out_t mk(input logic [3:0] b, input logic bs, input logic dn, input int s);
        out_t o;
        o.btn = b; o.busy = bs; o.done = dn; o.step = AW'(s); o.ab = 1'b0;
        return o;
    endfunction

    task automatic check(input string name, input out_t a, input out_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got btn=%b busy=%b done=%b step=%0d ab=%b, want btn=%b busy=%b done=%b step=%0d ab=%b",
                     name, a.btn, a.busy, a.done, a.step, a.ab, e.btn, e.busy, e.done, e.step, e.ab);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, a, e);
        end
    endtask

    function automatic out_t sample();
        out_t o;
        o.btn = {T, D, L, R}; o.busy = busy; o.done = done; o.step = step;
`ifdef KEY_SEQ_ABORT_EN
        o.ab = aborted;
`else
        o.ab = 1'b0;
`endif
        return o;
    endfunction

    // Model: a started playback expands into its full per-cycle output trace; the block accepts
    // start/write only when no trace cycles remain (idle, or the done cycle just ended).
    task automatic model_edge();
        bit accept;
        int n;
        accept = (q.size() == 0);
        if (rst) begin
            q.delete();
            exp_cur = '0;
            return;
        end
`ifdef KEY_SEQ_ABORT_EN
        if (abort && exp_cur.busy) begin
            q.delete();
            exp_cur = '0;
            exp_cur.ab = 1'b1;
            return;
        end
`endif
        if (accept && wr_en) mmem[wr_addr] = wr_dir;
        if (accept && start) begin
            n = (int'(seq_len) > MAX_LEN) ? MAX_LEN : int'(seq_len);
            for (int i = 0; i < n; i++) begin
                repeat (HOLD) q.push_back(mk(onehot(mmem[i]), 1'b1, 1'b0, i));
                repeat (GAP)  q.push_back(mk(4'b0000, 1'b1, 1'b0, i));
            end
            q.push_back(mk(4'b0000, 1'b0, 1'b1, 0));
        end
        exp_cur = (q.size() != 0) ? q.pop_front() : '0;
    endtask

    task automatic clr();
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_dir = 2'b00; start = 1'b0; seq_len = '0;
`ifdef KEY_SEQ_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        act = sample();
        check("model", act, exp_cur);
    endtask

    // Plays 4 entries whose codes are packed entry i at codes[2i+:2]; checks against fixed timing.
    task automatic play4(input string tag, input logic [7:0] codes, input int pulse_c,
                         input int wr_c, input bit wr_at_start);
        int   ndone;
        int   e;
        out_t x;
        ndone = 0;
        for (int c = 1; c <= 30; c++) begin
            clr();
            if (c == 1) begin
                start = 1'b1; seq_len = 4'd4;
                if (wr_at_start) begin wr_en = 1'b1; wr_addr = 3'd0; wr_dir = 2'b01; end
            end
            if (c == pulse_c) begin start = 1'b1; seq_len = 4'd4; end
            if (c == wr_c) begin wr_en = 1'b1; wr_addr = 3'd1; wr_dir = 2'b11; end
            tick();
            x = '0;
            if (c <= 24) begin
                e = (c - 1) / 6;
                x.busy = 1'b1;
                x.step = AW'(e);
                if ((c - 1) % 6 < HOLD) x.btn = onehot(codes[2*e +: 2]);
            end else if (c == 25) begin
                x.done = 1'b1;
            end
            check(tag, act, x);
            if (act.done) ndone++;
        end
        check_int({tag, "_ndone"}, ndone, 1);
    endtask

    localparam logic [7:0] TLLR = 8'b11_10_10_00;
    localparam logic [7:0] DRLR = 8'b11_10_11_01;

    vec_t tbl[16];
    logic [1:0] dirs [8];

    initial begin
        int ndone;
        out_t x;
        clr();
        rst = 1'b1;

        dirs = '{2'b00, 2'b10, 2'b10, 2'b11, 2'b01, 2'b11, 2'b00, 2'b10};
        tbl[0]  = '{1, 0, 0, 0, 0, 0,     4'b0000, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0,     4'b0000, 0, 0, 0};
        for (int i = 0; i < 8; i++)
            tbl[2+i] = '{0, 1, AW'(i), dirs[i], 0, 0, 4'b0000, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 1, 4'd0,  4'b0000, 0, 1, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 0,     4'b0000, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 1, 4'd12, 4'b1000, 1, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0,     4'b1000, 1, 0, 0};
        tbl[14] = '{1, 0, 0, 0, 0, 0,     4'b0000, 0, 0, 0};
        tbl[15] = '{0, 0, 0, 0, 0, 0,     4'b0000, 0, 0, 0};

        for (int i = 0; i < 16; i++) begin
            clr();
            rst = tbl[i].rst; wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_dir = tbl[i].wd;
            start = tbl[i].st; seq_len = tbl[i].sl;
            tick();
            check($sformatf("tbl%0d", i), act,
                  mk(tbl[i].btn, tbl[i].busy, tbl[i].done, int'(tbl[i].step)));
        end

        play4("tllr", TLLR, 0, 0, 1'b0);
        play4("start_in_hold", TLLR, 8, 0, 1'b0);
        play4("wr_drop", TLLR, 0, 3, 1'b0);
        play4("after_drop", TLLR, 0, 0, 1'b0);

        clr(); wr_en = 1'b1; wr_addr = 3'd1; wr_dir = 2'b11; tick();
        play4("wr_idle", DRLR, 0, 0, 1'b1);
        clr(); wr_en = 1'b1; wr_addr = 3'd0; wr_dir = 2'b00; tick();
        clr(); wr_en = 1'b1; wr_addr = 3'd1; wr_dir = 2'b10; tick();

        // Reset in the gap of entry 2.
        for (int c = 1; c <= 17; c++) begin
            clr();
            if (c == 1) begin start = 1'b1; seq_len = 4'd4; end
            if (c == 17) rst = 1'b1;
            tick();
        end
        check("rst_mid", act, '0);
        ndone = 0;
        repeat (10) begin clr(); tick(); if (act.done) ndone++; end
        check_int("rst_no_done", ndone, 0);
        play4("fresh", TLLR, 0, 0, 1'b0);

        // Back-to-back: restart accepted in the done cycle.
        for (int c = 1; c <= 8; c++) begin
            clr();
            if (c == 1 || c == 8) begin start = 1'b1; seq_len = 4'd1; end
            tick();
            if (c == 7) check("b2b_done", act, mk(4'b0000, 1'b0, 1'b1, 0));
        end
        check("b2b_restart", act, mk(4'b1000, 1'b1, 1'b0, 0));
        repeat (7) begin clr(); tick(); end

`ifdef KEY_SEQ_ABORT_EN
        clr(); start = 1'b1; seq_len = 4'd4; tick();
        clr(); abort = 1'b1; tick();
        x = '0; x.ab = 1'b1;
        check("abort_hold", act, x);
        ndone = 0;
        repeat (10) begin clr(); tick(); if (act.done) ndone++; end
        check("abort_after", act, '0);
        check_int("abort_no_done", ndone, 0);
        clr(); abort = 1'b1; tick();
        check("abort_idle", act, '0);
`endif

        for (int n = 0; n < 3000; n++) begin
            clr();
            rst     = ($urandom_range(0, 299) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = AW'($urandom);
            wr_dir  = 2'($urandom);
            start   = ($urandom_range(0, 5) == 0);
            seq_len = LW'($urandom_range(0, 10));
`ifdef KEY_SEQ_ABORT_EN
            abort   = ($urandom_range(0, 39) == 0);
`endif
            tick();
        end

        x = '0;
        x = mk(4'b0000, 1'b0, 1'b0, 0);
        clr(); rst = 1'b1; tick();
        check("final_rst", act, x);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
